// File: rtl/conv1_image_loader.sv
// conv1_image_loader: binarizes a raster-order 8-bit pixel stream into a held
// IMG_DIM x IMG_DIM bit image, then starts the conv1 engine and holds the
// image until the engine reports completion.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pix_data/valid/sof/last, pix_ready   pixel stream (valid/ready handshake)
//   image               binarized image, indexed [row][col]
//   begin_conv          one-cycle start pulse to the conv1 engine
//   done_conv           completion pulse from the conv1 engine
//   busy                high whenever the loader is not in LOAD
//   frame_err           one-cycle pulse on a framing violation
module conv1_image_loader #(
    parameter int unsigned IMG_DIM = 28,
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned THRESH  = 128
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [PIX_W-1:0]                    pix_data,
    input  logic                                pix_valid,
    input  logic                                pix_sof,
    input  logic                                pix_last,
    output logic                                pix_ready,
    output logic [0:IMG_DIM-1][0:IMG_DIM-1]     image,
    output logic                                begin_conv,
    input  logic                                done_conv,
    output logic                                busy,
    output logic                                frame_err
);

    localparam int unsigned CNT_W = $clog2(IMG_DIM);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_DIM - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_START = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]                            state_q, state_d;
    logic [CNT_W-1:0]                      row_q, row_d;
    logic [CNT_W-1:0]                      col_q, col_d;
    logic [0:IMG_DIM-1][0:IMG_DIM-1]       image_q, image_d;
    logic                                  err_d;
    logic                                  ready_q, busy_q, begin_q, err_q;
    // Set during the first WAIT cycle, when the engine's done may still be stale
    logic                                  wait_first_q;

    logic accept;
    logic pix_bit;
    logic at_origin;
    logic at_end;

    assign accept    = pix_valid && ready_q;
    assign pix_bit   = (pix_data >= PIX_W'(THRESH));
    assign at_origin = (row_q == '0) && (col_q == '0);
    assign at_end    = (row_q == LAST_IDX) && (col_q == LAST_IDX);

    // Next-state, counter and image update logic
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        image_d = image_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_LOAD;
            S_LOAD: begin
                if (accept) begin
                    if (pix_sof && !at_origin) begin
                        // Restart: discard the partial frame, this pixel is (0,0)
                        err_d         = 1'b1;
                        image_d[0][0] = pix_bit;
                        row_d         = '0;
                        col_d         = CNT_W'(1);
                    end else begin
                        image_d[row_q][col_q] = pix_bit;
                        if (pix_last && !at_end) begin
                            err_d = 1'b1;
                            row_d = '0;
                            col_d = '0;
                        end else if (at_end) begin
                            // Frame is complete even if pix_last is missing
                            err_d   = !pix_last;
                            row_d   = '0;
                            col_d   = '0;
                            state_d = S_START;
                        end else if (col_q == LAST_IDX) begin
                            col_d = '0;
                            row_d = CNT_W'(row_q + 1'b1);
                        end else begin
                            col_d = CNT_W'(col_q + 1'b1);
                        end
                    end
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (done_conv && !wait_first_q) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            image_q      <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
            begin_q      <= 1'b0;
            err_q        <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            image_q      <= image_d;
            ready_q      <= (state_d == S_LOAD);
            busy_q       <= (state_d != S_LOAD);
            begin_q      <= (state_d == S_START);
            err_q        <= err_d;
            wait_first_q <= (state_q == S_START);
        end
    end

    assign pix_ready  = ready_q;
    assign busy       = busy_q;
    assign begin_conv = begin_q;
    assign frame_err  = err_q;
    assign image      = image_q;

endmodule
